fifo_read_ctrl: RTL

Read-domain controller for the asynchronous FIFO, sitting directly between the write-pointer crossing and the read pointer. It synchronizes the write-side Gray pointer into the read clock domain and compares it with the read pointer to produce the empty and almost-empty flags and the fill level. It gates the consumer's read request into the pointer increment `Rinc`, and drives the memory read address and a read-data-valid strobe. It also flags underflow attempts.

---
 rtl/fifo_read_ctrl.sv | 79 +++++++
 1 files changed

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the asynchronous FIFO. It brings the write pointer into
// R_CLK, derives the empty/almost-empty flags and fill level, and gates read requests.
module fifo_read_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  R_CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH:0]   Wptr_grey,
  input  logic [ADDR_WIDTH:0]   read_ptr_grey,
  input  logic [ADDR_WIDTH:0]   read_ptr_reg,
  input  logic                  Rreq,
  output logic                  Rinc,
  output logic [ADDR_WIDTH-1:0] Raddr,
  output logic                  Rempty,
  output logic                  Ralmost_empty,
  output logic [ADDR_WIDTH:0]   Rlevel,
  output logic                  Rvalid,
  output logic                  Runderflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AEMPTY_THRESH = PW'(AEMPTY_LEVEL);

  logic [SYNC_STAGES-1:0][PW-1:0] sync_reg;
  logic [PW-1:0] wsync;
  logic [PW-1:0] wbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] level_reg;
  logic          aempty_reg;
  logic          valid_reg;
  logic          underflow_reg;

  // Plain shift register: nothing may sit between stages of the crossing.
  always_ff @(posedge R_CLK or posedge RST) begin
    if (RST) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], Wptr_grey};
    end
  end

  assign wsync = sync_reg[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign wbin[gi] = ^wsync[PW-1:gi];
    end
  endgenerate

  assign level_next = wbin - read_ptr_reg;

  assign Rempty = (wsync == read_ptr_grey);
  assign Rinc   = Rreq & ~Rempty;
  assign Raddr  = read_ptr_reg[ADDR_WIDTH-1:0];

  always_ff @(posedge R_CLK or posedge RST) begin
    if (RST) begin
      level_reg     <= '0;
      aempty_reg    <= 1'b1;
      valid_reg     <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      level_reg     <= level_next;
      aempty_reg    <= (level_next <= AEMPTY_THRESH);
      valid_reg     <= Rinc;
      underflow_reg <= underflow_reg | (Rreq & Rempty);
    end
  end

  assign Rlevel        = level_reg;
  assign Ralmost_empty = aempty_reg;
  assign Rvalid        = valid_reg;
  assign Runderflow    = underflow_reg;

endmodule
